dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 = CPU load/store unit, port 1 = DMA/debug.
//  One access is granted per cycle, with port 0 priority and an anti-starvation override for port 1.
//  Read data is routed back to the port that issued the read, one cycle after grant (memory read latency is 1).
//  Out-of-range word addresses are blocked and reported as errors.
// PARAMETERS
//  MEM_WORDS  4096  data memory depth in 32-bit words; word index = addr[31:2]
//  MAX_WAIT   4     consecutive cycles port 1 may wait before it overrides port 0 (1..15)
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst          in   1   synchronous reset, active high
//  p0_req       in   1   port 0 access request, held until p0_gnt
//  p0_we        in   1   1 = store, 0 = load
//  p0_addr      in   32  byte address
//  p0_wdata     in   32  store data
//  p0_wstrb     in   4   store byte enables (ignored when p0_we=0)
//  p0_gnt       out  1   request accepted this cycle (combinational)
//  p0_rvalid    out  1   load response valid (registered)
//  p0_rdata     out  32  load data, valid with p0_rvalid
//  p0_err       out  1   out-of-range response, valid with p0_rvalid
//  p1_*         -    -   identical set for port 1
//  mem_addr     out  32  to memory: byte address of granted access
//  mem_sdata    out  32  to memory: store data
//  mem_lenable  out  1   to memory: load enable
//  mem_mask     out  4   to memory: byte write mask
//  mem_ldata    in   32  from memory: read data, one cycle after mem_lenable
// BEHAVIOUR
//  Reset (rst=1 at posedge): p0_rvalid/p1_rvalid/p*_err=0, p*_rdata=0, wait_cnt=0, rsp_owner=none.
//   While rst is high: gnt=0 on both ports, mem_lenable=0, mem_mask=0.
//  Arbitration (combinational, per cycle):
//   - only p0_req -> grant 0; only p1_req -> grant 1; neither -> no grant.
//   - both: grant 0 unless wait_cnt >= MAX_WAIT, then grant 1.
//   - Exactly one gnt or none; a port's gnt is never high without its req.
//  wait_cnt (4 bit): +1 each cycle p1_req=1 and p1 is not granted; cleared when p1 is granted or p1_req=0; saturates at 15.
//  Memory drive: mem_addr/mem_sdata = granted port's addr/wdata; with no grant, mem_addr=0 and mem_sdata=0.
//   Granted load:  mem_lenable=1, mem_mask=0.
//   Granted store: mem_lenable=0, mem_mask=wstrb.
//   No grant:      mem_lenable=0, mem_mask=0.
//  Range check: addr[31:2] >= MEM_WORDS -> access is granted (the handshake completes), but mem_lenable=0 and mem_mask=0.
//  Response (registered): a load granted in cycle N gives the owning port rvalid=1 for exactly cycle N+1.
//   - In range: rdata = mem_ldata, err=0.
//   - Out of range: rdata = 0, err=1.
//  Out-of-range store: p*_rvalid=1 and err=1 in cycle N+1, rdata=0. In-range stores produce no response.
//  Throughput: one access per cycle. Back-to-back loads on alternating ports are allowed.
//   rsp_owner is pipelined so that each response goes to the correct port.
//  The non-owning port's rvalid stays 0. Its rdata holds its last value; its err is 0.
//  Reset asserted in cycle N+1 of an outstanding load: the response is dropped (rvalid=0 after reset).
//  Any store already masked into memory stays committed.
// TESTING
//  1. p0 load addr 0x10 (MEM[4]=0xDEADBEEF) -> p0_gnt same cycle, mem_lenable=1; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF, p1_rvalid=0.
//  2. p0 store 0x11223344, wstrb=4'b0101, addr 0x20, then load 0x20 -> rdata = {old[31:24],0x22,old[15:8],0x44}.
//  3. p0_req and p1_req held high, MAX_WAIT=4 -> p0 granted 4 cycles, p1 granted in cycle 5, wait_cnt cleared, p0 resumes.
//  4. Alternating loads p0@0x0, p1@0x4, p0@0x8 in consecutive cycles -> each port gets rvalid in the next cycle with its own word; no cross-delivery.
//  5. p1 load addr 0x4000 (MEM_WORDS=4096) -> p1_gnt=1, mem_lenable=0; next cycle p1_rvalid=1, p1_err=1, p1_rdata=0.
//     p1 store to 0x4000 -> mem_mask=0, err response next cycle.
//  6. rst pulsed the cycle after a p0 load grant -> p0_rvalid=0, gnt=0 during rst; normal operation resumes the cycle after rst falls.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 has priority,
// port 1 wins after MAX_WAIT consecutive stalled cycles; responses follow one cycle later.
module dmem_arbiter #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wstrb,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wstrb,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_sdata,
    output logic        mem_lenable,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_ldata
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    typedef enum logic [1:0] {OwnNone, OwnP0, OwnP1} owner_e;

    owner_e      rsp_owner_q, rsp_owner_d;
    logic        rsp_err_q, rsp_err_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] p0_rdata_q, p1_rdata_q;

    logic        any_gnt, sel_we, in_range;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_wstrb;

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (p0_req && p1_req) begin
                if (wait_q >= MaxWait) p1_gnt = 1'b1;
                else                   p0_gnt = 1'b1;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    always_comb begin
        any_gnt   = p0_gnt | p1_gnt;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        if (p0_gnt) begin
            sel_we    = p0_we;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
            sel_wstrb = p0_wstrb;
        end else if (p1_gnt) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
            sel_wstrb = p1_wstrb;
        end
        in_range = ({2'b00, sel_addr[31:2]} < MEM_WORDS);
    end

    // Out-of-range accesses still complete the handshake but never reach the memory.
    always_comb begin
        mem_addr    = sel_addr;
        mem_sdata   = sel_wdata;
        mem_lenable = any_gnt && !sel_we && in_range;
        mem_mask    = (any_gnt && sel_we && in_range) ? sel_wstrb : 4'b0000;
    end

    always_comb begin
        rsp_owner_d = OwnNone;
        rsp_err_d   = 1'b0;
        if (any_gnt && (!sel_we || !in_range)) begin
            rsp_owner_d = p1_gnt ? OwnP1 : OwnP0;
            rsp_err_d   = !in_range;
        end
        wait_d = 4'd0;
        if (p1_req && !p1_gnt) begin
            wait_d = (wait_q == 4'hf) ? wait_q : wait_q + 4'd1;
        end
    end

    // Responses are squashed while reset is high so an in-flight load is dropped.
    always_comb begin
        p0_rvalid = (rsp_owner_q == OwnP0) && !rst;
        p1_rvalid = (rsp_owner_q == OwnP1) && !rst;
        p0_err    = p0_rvalid && rsp_err_q;
        p1_err    = p1_rvalid && rsp_err_q;
        p0_rdata  = p0_rvalid ? (rsp_err_q ? 32'd0 : mem_ldata) : p0_rdata_q;
        p1_rdata  = p1_rvalid ? (rsp_err_q ? 32'd0 : mem_ldata) : p1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_owner_q <= OwnNone;
            rsp_err_q   <= 1'b0;
            wait_q      <= 4'd0;
            p0_rdata_q  <= 32'd0;
            p1_rdata_q  <= 32'd0;
        end else begin
            rsp_owner_q <= rsp_owner_d;
            rsp_err_q   <= rsp_err_d;
            wait_q      <= wait_d;
            p0_rdata_q  <= p0_rdata;
            p1_rdata_q  <= p1_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a response scoreboard.
module tb_dmem_arbiter;

    localparam int unsigned MEM_WORDS = 4096;
    localparam int unsigned MAX_WAIT  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [3:0]  p0_wstrb = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [3:0]  p1_wstrb = '0;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_sdata;
    logic        mem_lenable;
    logic [3:0]  mem_mask;
    logic [31:0] mem_ldata = '0;

    dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wstrb(p0_wstrb), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wstrb(p1_wstrb), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_sdata(mem_sdata), .mem_lenable(mem_lenable),
        .mem_mask(mem_mask), .mem_ldata(mem_ldata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_mask[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_sdata[8*b +: 8];
        if (mem_lenable) mem_ldata <= mem[mem_addr[13:2]];
    end

    typedef struct {
        int          cyc;
        bit          port;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    int          total = 0;
    int          fails = 0;
    int          cyc = 0;
    int          wait_m = 0;
    logic [31:0] last0 = '0, last1 = '0;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_wstrb = strb;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_wstrb = strb;
    endtask

    // Check this cycle's outputs against the model, then record what the grant implies.
    task automatic eval();
        rsp_t        e;
        bit          v0, v1, g0, g1, gw, inr;
        logic [31:0] d, ga, gd;
        logic [3:0]  gs;
        logic        er;
        #1;
        v0 = 0; v1 = 0; d = '0; er = 1'b0;
        if (rst) sb.delete();
        else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (e.port) v1 = 1; else v0 = 1;
            d = e.data; er = e.err;
        end
        chk("p0_rvalid", p0_rvalid, v0);
        chk("p1_rvalid", p1_rvalid, v1);
        chk("p0_err", p0_err, v0 & er);
        chk("p1_err", p1_err, v1 & er);
        if (!rst) begin
            chk("p0_rdata", p0_rdata, v0 ? d : last0);
            chk("p1_rdata", p1_rdata, v1 ? d : last1);
            if (v0) last0 = d;
            if (v1) last1 = d;
        end else begin
            last0 = '0; last1 = '0;
        end

        g0 = 0; g1 = 0;
        if (!rst) begin
            if (p0_req && p1_req) begin
                if (wait_m >= int'(MAX_WAIT)) g1 = 1; else g0 = 1;
            end else begin
                g0 = p0_req; g1 = p1_req;
            end
        end
        chk("p0_gnt", p0_gnt, g0);
        chk("p1_gnt", p1_gnt, g1);
        gw = g1 ? p1_we : p0_we;
        ga = g0 ? p0_addr : (g1 ? p1_addr : 32'd0);
        gd = g0 ? p0_wdata : (g1 ? p1_wdata : 32'd0);
        gs = g1 ? p1_wstrb : p0_wstrb;
        inr = ({2'b00, ga[31:2]} < MEM_WORDS);
        chk("mem_addr", mem_addr, ga);
        chk("mem_sdata", mem_sdata, gd);
        chk("mem_lenable", mem_lenable, (g0 | g1) && !gw && inr);
        chk("mem_mask", mem_mask, ((g0 | g1) && gw && inr) ? gs : 4'b0000);

        if ((g0 | g1) && (!gw || !inr)) begin
            e.cyc  = cyc + 1;
            e.port = g1;
            e.data = (inr && !gw) ? ref_mem[ga[13:2]] : 32'd0;
            e.err  = !inr;
            sb.push_back(e);
        end
        if ((g0 | g1) && gw && inr)
            for (int b = 0; b < 4; b++)
                if (gs[b]) ref_mem[ga[13:2]][8*b +: 8] = gd[8*b +: 8];
        if (rst || !p1_req || g1) wait_m = 0;
        else if (wait_m < 15) wait_m++;
    endtask

    task automatic step();
        eval();
        tick();
    endtask

    task automatic idle();
        set_p0(0, 0, 32'd0, 32'd0, 4'b0000);
        set_p1(0, 0, 32'd0, 32'd0, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        mem[4]     = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;

        // Reset with both ports requesting: nothing may be granted.
        rst = 1'b1;
        set_p0(1, 0, 32'h10, 32'd0, 4'b0000);
        set_p1(1, 1, 32'h20, 32'hFFFF_FFFF, 4'b1111);
        step();
        step();
        rst = 1'b0;
        idle();
        step();
        chk("reset_p0_rdata", p0_rdata, 32'd0);
        chk("reset_p1_rdata", p1_rdata, 32'd0);

        // Test 1: plain load.
        set_p0(1, 0, 32'h10, 32'd0, 4'b0000);
        step();
        idle();
        eval();
        chk("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
        tick();

        // Test 2: masked store then reload.
        old = init_word(8);
        set_p0(1, 1, 32'h20, 32'h1122_3344, 4'b0101);
        step();
        set_p0(1, 0, 32'h20, 32'd0, 4'b0000);
        step();
        idle();
        eval();
        chk("t2_merge", p0_rdata, {old[31:24], 8'h22, old[15:8], 8'h44});
        tick();

        // Test 3: contention, port 1 wins on the fifth cycle.
        set_p0(1, 0, 32'h30, 32'd0, 4'b0000);
        set_p1(1, 0, 32'h44, 32'd0, 4'b0000);
        for (int i = 0; i < 7; i++) begin
            eval();
            chk("t3_p1_gnt", p1_gnt, (i == 4) ? 1'b1 : 1'b0);
            tick();
        end
        idle();
        step();

        // Test 4: alternating loads on consecutive cycles.
        set_p0(1, 0, 32'h0, 32'd0, 4'b0000);
        step();
        set_p0(0, 0, 32'd0, 32'd0, 4'b0000);
        set_p1(1, 0, 32'h4, 32'd0, 4'b0000);
        step();
        set_p1(0, 0, 32'd0, 32'd0, 4'b0000);
        set_p0(1, 0, 32'h8, 32'd0, 4'b0000);
        step();
        idle();
        step();
        step();

        // Test 5: out-of-range load and store from port 1.
        set_p1(1, 0, 32'h4000, 32'd0, 4'b0000);
        step();
        set_p1(1, 1, 32'h4000, 32'hCAFE_F00D, 4'b1111);
        eval();
        chk("t5_load_err", p1_err, 1'b1);
        tick();
        idle();
        eval();
        chk("t5_store_err", p1_err, 1'b1);
        tick();

        // Test 6: reset lands on the response cycle of a load.
        set_p0(1, 0, 32'h10, 32'd0, 4'b0000);
        step();
        rst = 1'b1;
        set_p1(1, 0, 32'h4, 32'd0, 4'b0000);
        eval();
        chk("t6_rvalid_in_rst", p0_rvalid, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        eval();
        chk("t6_rvalid_after_rst", p0_rvalid, 1'b0);
        tick();
        set_p0(1, 0, 32'h10, 32'd0, 4'b0000);
        step();
        idle();
        eval();
        chk("t6_resume", p0_rdata, 32'hDEAD_BEEF);
        tick();
        step();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
